// File: rtl/load_store_unit_if.sv
// Request, response and RAM-port signals of the load/store unit.
// master = pipeline + RAM side, slave = the unit itself.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        addr_err;
   logic [31:0] ld_data;
   logic        ram_read;
   logic        ram_write;
   logic [3:0]  ram_be;
   logic [31:0] ram_adr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata, ram_rdata,
      input  req_ready, resp_valid, addr_err, ld_data,
      input  ram_read, ram_write, ram_be, ram_adr, ram_wdata
   );

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata, ram_rdata,
      output req_ready, resp_valid, addr_err, ld_data,
      output ram_read, ram_write, ram_be, ram_adr, ram_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, byte-enabled RAM access,
// big-endian load extraction with sign/zero extension.
module load_store_unit #(
   parameter int unsigned RAM_LATENCY = 1
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
   localparam int unsigned CW = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [1:0]    lane_q, lane_d;
   logic          resp_valid_q, resp_valid_d;
   logic          addr_err_q, addr_err_d;
   logic          ram_read_q, ram_read_d;
   logic          ram_write_q, ram_write_d;
   logic [3:0]    ram_be_q, ram_be_d;
   logic [31:0]   ram_adr_q, ram_adr_d;
   logic [31:0]   ram_wdata_q, ram_wdata_d;
   logic [31:0]   ld_data_q, ld_data_d;

   logic          req_b, req_h, mis;
   logic [3:0]    be_req;
   logic [31:0]   wdata_req;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_ext;

   // Decode the incoming request: size, alignment, lanes and replicated data.
   always_comb begin
      req_b = (bus.req_op == 3'b000) || (bus.req_op == 3'b100);
      req_h = (bus.req_op == 3'b001) || (bus.req_op == 3'b101);
      mis = (req_h && bus.req_addr[0]) ||
            (!req_b && !req_h && (bus.req_addr[1:0] != 2'b00));
      be_req = 4'b1111;
      wdata_req = bus.req_wdata;
      if (req_b) begin
         be_req = 4'b1000 >> bus.req_addr[1:0];
         wdata_req = {4{bus.req_wdata[7:0]}};
      end else if (req_h) begin
         be_req = bus.req_addr[1] ? 4'b0011 : 4'b1100;
         wdata_req = {2{bus.req_wdata[15:0]}};
      end
   end

   // Pick the addressed byte/halfword of the RAM word and extend it.
   always_comb begin
      byte_sel = bus.ram_rdata[31:24];
      case (lane_q)
         2'd0: byte_sel = bus.ram_rdata[31:24];
         2'd1: byte_sel = bus.ram_rdata[23:16];
         2'd2: byte_sel = bus.ram_rdata[15:8];
         2'd3: byte_sel = bus.ram_rdata[7:0];
         default: byte_sel = bus.ram_rdata[31:24];
      endcase
      half_sel = lane_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
      ld_ext = bus.ram_rdata;
      if (size_q == 2'd0) begin
         ld_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end else if (size_q == 2'd1) begin
         ld_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
   end

   // Next-state and registered-output logic of the IDLE/BUSY/RESP sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      size_d       = size_q;
      uns_d        = uns_q;
      lane_d       = lane_q;
      resp_valid_d = 1'b0;
      addr_err_d   = 1'b0;
      ram_read_d   = ram_read_q;
      ram_write_d  = ram_write_q;
      ram_be_d     = ram_be_q;
      ram_adr_d    = ram_adr_q;
      ram_wdata_d  = ram_wdata_q;
      ld_data_d    = ld_data_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (mis) begin
                  resp_valid_d = 1'b1;
                  addr_err_d   = 1'b1;
               end else begin
                  state_d     = BUSY;
                  cnt_d       = CW'(RAM_LATENCY);
                  size_d      = req_b ? 2'd0 : (req_h ? 2'd1 : 2'd2);
                  uns_d       = bus.req_op[2] && (req_b || req_h);
                  lane_d      = bus.req_addr[1:0];
                  ram_read_d  = !bus.req_we;
                  ram_write_d = bus.req_we;
                  ram_be_d    = be_req;
                  ram_adr_d   = {bus.req_addr[31:2], 2'b00};
                  ram_wdata_d = wdata_req;
               end
            end
         end
         BUSY: begin
            if (cnt_q == CW'(1)) begin
               state_d      = RESP;
               ram_read_d   = 1'b0;
               ram_write_d  = 1'b0;
               resp_valid_d = 1'b1;
               if (ram_read_q) ld_data_d = ld_ext;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops strobes without a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         lane_q       <= 2'd0;
         resp_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
         ram_read_q   <= 1'b0;
         ram_write_q  <= 1'b0;
         ram_be_q     <= 4'b0;
         ram_adr_q    <= 32'b0;
         ram_wdata_q  <= 32'b0;
         ld_data_q    <= 32'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         lane_q       <= lane_d;
         resp_valid_q <= resp_valid_d;
         addr_err_q   <= addr_err_d;
         ram_read_q   <= ram_read_d;
         ram_write_q  <= ram_write_d;
         ram_be_q     <= ram_be_d;
         ram_adr_q    <= ram_adr_d;
         ram_wdata_q  <= ram_wdata_d;
         ld_data_q    <= ld_data_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign bus.resp_valid = resp_valid_q;
   assign bus.addr_err   = addr_err_q;
   assign bus.ld_data    = ld_data_q;
   assign bus.ram_read   = ram_read_q;
   assign bus.ram_write  = ram_write_q;
   assign bus.ram_be     = ram_be_q;
   assign bus.ram_adr    = ram_adr_q;
   assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, latency/reset
// sequences and random requests against a byte-array memory model.
module tb_load_store_unit;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.RAM_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  ram_mem [0:63];
   logic [7:0]  mref [0:63];
   logic [31:0] ld_exp = 32'h0;
   logic [5:0]  rb;

   // RAM device: combinational read of the addressed word, byte-enabled writes.
   always_comb begin
      rb = {bus.ram_adr[5:2], 2'b00};
      bus.ram_rdata = {ram_mem[rb], ram_mem[rb + 6'd1],
                       ram_mem[rb + 6'd2], ram_mem[rb + 6'd3]};
   end

   initial begin
      for (int i = 0; i < 64; i++) ram_mem[i] = 8'h00;
      ram_mem[4] = 8'h80; ram_mem[5] = 8'hFF;
      ram_mem[6] = 8'h12; ram_mem[7] = 8'h34;
      forever begin
         @(posedge clk);
         if (bus.ram_write) begin
            for (int j = 0; j < 4; j++)
               if (bus.ram_be[3-j])
                  ram_mem[int'(bus.ram_adr[5:0]) + j] <= bus.ram_wdata[31-8*j -: 8];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] op);
      if (op == 3'b000 || op == 3'b100) return 1;
      if (op == 3'b001 || op == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic is_mis(input logic [2:0] op, input logic [31:0] a);
      return (int'(a[1:0]) % size_of(op)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
      logic [31:0] v = 32'h0;
      int n = size_of(op);
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mref[int'(a[5:0]) + i]};
      if (op == 3'b000) v = {{24{v[7]}}, v[7:0]};
      if (op == 3'b001) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   function automatic void model_store(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] wd);
      int n = size_of(op);
      logic [31:0] s;
      for (int i = 0; i < n; i++) begin
         s = wd >> (8 * (n - 1 - i));
         mref[int'(a[5:0]) + i] = s[7:0];
      end
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
      logic [3:0] be = 4'h0;
      for (int i = 0; i < size_of(op); i++) be[3 - ((int'(a[1:0]) + i) % 4)] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] op, input logic [31:0] wd);
      logic [31:0] v = 32'h0;
      logic [31:0] s;
      int n = size_of(op);
      for (int j = 0; j < 4; j++) begin
         s = wd >> (8 * (n - 1 - (j % n)));
         v[31-8*j -: 8] = s[7:0];
      end
      return v;
   endfunction

   // One request: wait for ready, present for one edge, observe LAT+4 cycles.
   task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_ld,
                         input logic exp_err);
      int t = 0;
      int nstb = 0, nresp = 0, resp_c = 0;
      logic err_seen = 1'b0, portbad = 1'b0, rdybad = 1'b0, overlap = 1'b0;
      logic [31:0] ld_seen = 32'h0;
      logic mis = is_mis(op, addr);
      @(negedge clk);
      while (!bus.req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", {31'b0, bus.req_ready}, 32'd1);
      bus.req_we = we; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= LAT + 4; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.ram_read || bus.ram_write) begin
            nstb++;
            if (bus.ram_read == we || bus.ram_write != we) portbad = 1'b1;
            if (bus.ram_adr !== {addr[31:2], 2'b00}) portbad = 1'b1;
            if (bus.ram_be !== model_be(op, addr)) portbad = 1'b1;
            if (we && bus.ram_wdata !== model_wd(op, wd)) portbad = 1'b1;
            if (bus.resp_valid) overlap = 1'b1;
         end
         if (bus.resp_valid) begin
            if (nresp == 0) begin
               resp_c = c;
               err_seen = bus.addr_err;
               ld_seen = bus.ld_data;
            end
            nresp++;
         end
         if (!mis && c <= LAT + 1 && bus.req_ready) rdybad = 1'b1;
      end
      chk("resp_count", nresp, 1);
      chk("resp_cycle", resp_c, mis ? 1 : LAT + 1);
      chk("addr_err", {31'b0, err_seen}, {31'b0, exp_err});
      chk("ld_data", ld_seen, exp_ld);
      chk("strobe_cycles", nstb, mis ? 0 : LAT);
      if (!mis) begin
         chk("ram_port", {31'b0, portbad}, 32'd0);
         chk("ready_low_busy", {31'b0, rdybad}, 32'd0);
         chk("resp_strobe_overlap", {31'b0, overlap}, 32'd0);
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] ld;
      logic        err;
   } vec_t;

   vec_t tbl [18];

   initial begin
      int n_r, r1, r2;
      logic [31:0] ld1, ld2;
      logic rdy2, rd2;
      logic [3:0] be2;
      logic [2:0] rop;
      logic [31:0] raddr, rwd, rexp;
      logic rwe, rmis;

      tbl[0]  = '{1'b0, 3'b000, 32'd5,  32'h0,        32'hFFFFFFFF, 1'b0};
      tbl[1]  = '{1'b0, 3'b100, 32'd4,  32'h0,        32'h00000080, 1'b0};
      tbl[2]  = '{1'b0, 3'b001, 32'd4,  32'h0,        32'hFFFF80FF, 1'b0};
      tbl[3]  = '{1'b0, 3'b101, 32'd6,  32'h0,        32'h00001234, 1'b0};
      tbl[4]  = '{1'b0, 3'b011, 32'd4,  32'h0,        32'h80FF1234, 1'b0};
      tbl[5]  = '{1'b1, 3'b000, 32'd9,  32'h123456AB, 32'h80FF1234, 1'b0};
      tbl[6]  = '{1'b0, 3'b011, 32'd8,  32'h0,        32'h00AB0000, 1'b0};
      tbl[7]  = '{1'b0, 3'b011, 32'd6,  32'h0,        32'h00AB0000, 1'b1};
      tbl[8]  = '{1'b1, 3'b001, 32'd2,  32'h0000BEEF, 32'h00AB0000, 1'b0};
      tbl[9]  = '{1'b1, 3'b001, 32'd0,  32'h1234CAFE, 32'h00AB0000, 1'b0};
      tbl[10] = '{1'b0, 3'b011, 32'd0,  32'h0,        32'hCAFEBEEF, 1'b0};
      tbl[11] = '{1'b0, 3'b001, 32'd1,  32'h0,        32'hCAFEBEEF, 1'b1};
      tbl[12] = '{1'b0, 3'b000, 32'd3,  32'h0,        32'hFFFFFFEF, 1'b0};
      tbl[13] = '{1'b0, 3'b101, 32'd2,  32'h0,        32'h0000BEEF, 1'b0};
      tbl[14] = '{1'b0, 3'b111, 32'd4,  32'h0,        32'h80FF1234, 1'b0};
      tbl[15] = '{1'b0, 3'b110, 32'd5,  32'h0,        32'h80FF1234, 1'b1};
      tbl[16] = '{1'b1, 3'b011, 32'd12, 32'hDEADBEEF, 32'h80FF1234, 1'b0};
      tbl[17] = '{1'b0, 3'b001, 32'd12, 32'h0,        32'hFFFFDEAD, 1'b0};

      for (int i = 0; i < 64; i++) mref[i] = 8'h00;
      mref[4] = 8'h80; mref[5] = 8'hFF; mref[6] = 8'h12; mref[7] = 8'h34;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'b000;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      #12;
      chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("rst_resp", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_strobes", {30'b0, bus.ram_read, bus.ram_write}, 32'd0);
      chk("rst_be", {28'b0, bus.ram_be}, 32'd0);
      chk("rst_adr", bus.ram_adr, 32'd0);
      chk("rst_ld", bus.ld_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 18; i++) begin
         do_req(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].ld, tbl[i].err);
         if (tbl[i].we && !tbl[i].err) model_store(tbl[i].op, tbl[i].addr, tbl[i].wd);
      end
      ld_exp = 32'hFFFFDEAD;

      // Held req_valid: second request only taken once back in IDLE.
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_op = 3'b011; bus.req_addr = 32'd4;
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_op = 3'b000; bus.req_addr = 32'd7;
      n_r = 0; r1 = 0; r2 = 0; ld1 = 0; ld2 = 0; rdy2 = 0; rd2 = 0; be2 = 0;
      for (int c = 1; c <= 2 * LAT + 6; c++) begin
         if (c > 1) @(negedge clk);
         if (c == LAT + 3) begin
            bus.req_valid = 1'b0;
            rd2 = bus.ram_read;
            be2 = bus.ram_be;
         end
         if (c == LAT + 2) rdy2 = bus.req_ready;
         if (bus.resp_valid) begin
            if (n_r == 0) begin r1 = c; ld1 = bus.ld_data; end
            else if (n_r == 1) begin r2 = c; ld2 = bus.ld_data; end
            n_r++;
         end
      end
      chk("held_resp_count", n_r, 2);
      chk("held_resp1_cycle", r1, LAT + 1);
      chk("held_ld1", ld1, 32'h80FF1234);
      chk("held_ready_idle", {31'b0, rdy2}, 32'd1);
      chk("held_read2", {31'b0, rd2}, 32'd1);
      chk("held_be2", {28'b0, be2}, 32'h1);
      chk("held_resp2_cycle", r2, 2 * LAT + 3);
      chk("held_ld2", ld2, 32'h00000034);

      // Reset while BUSY: strobes drop at once, no response follows.
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_op = 3'b011; bus.req_addr = 32'd4;
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("busy_read", {31'b0, bus.ram_read}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_read", {31'b0, bus.ram_read}, 32'd0);
      chk("rst_async_ready", {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_r = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         if (bus.resp_valid) n_r++;
      end
      chk("rst_no_resp", n_r, 0);
      chk("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_ld_zero", bus.ld_data, 32'd0);
      ld_exp = 32'h0;

      for (int k = 0; k < 60; k++) begin
         rwe = 1'($urandom_range(0, 1));
         rop = 3'($urandom_range(0, 7));
         raddr = 32'($urandom_range(0, 63));
         rwd = $urandom;
         rmis = is_mis(rop, raddr);
         rexp = (!rwe && !rmis) ? model_load(rop, raddr) : ld_exp;
         do_req(rwe, rop, raddr, rwd, rexp, rmis);
         if (rwe && !rmis) model_store(rop, raddr, rwd);
         ld_exp = rexp;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
